// File: rtl/seq_pkg.sv
// Shared types, fixed colour tables, LFSR taps and one-hot helper for seq_player.
// Pure definitions; no latency and no flow control apply here.
package seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GEN,
        ST_ON,
        ST_OFF,
        ST_DONE
    } state_t;

    localparam int TBL_LEN    = 16;
    localparam int MAX_COLORS = 8;

    // Two bits per entry, entry 0 in the LSBs. Bank 1 is bank 0 reversed.
    localparam logic [2*TBL_LEN-1:0] BANK0_TBL = {
        2'd0, 2'd3, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd0,
        2'd2, 2'd3, 2'd0, 2'd1, 2'd3, 2'd0, 2'd2, 2'd0
    };
    localparam logic [2*TBL_LEN-1:0] BANK1_TBL = {
        2'd0, 2'd2, 2'd0, 2'd3, 2'd1, 2'd0, 2'd3, 2'd2,
        2'd0, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd3, 2'd0
    };

    // Maximal-length Fibonacci tap masks; bit k set means l[k] feeds back.
    function automatic logic [31:0] lfsr_taps(input int w);
        logic [31:0] m;
        case (w)
            4:       m = 32'h0000_000C;
            5:       m = 32'h0000_0014;
            6:       m = 32'h0000_0030;
            7:       m = 32'h0000_0060;
            8:       m = 32'h0000_00B8;
            9:       m = 32'h0000_0110;
            10:      m = 32'h0000_0240;
            11:      m = 32'h0000_0500;
            12:      m = 32'h0000_0E08;
            13:      m = 32'h0000_1C80;
            14:      m = 32'h0000_3802;
            15:      m = 32'h0000_6000;
            17:      m = 32'h0001_2000;
            18:      m = 32'h0002_0400;
            19:      m = 32'h0007_2000;
            20:      m = 32'h0009_0000;
            24:      m = 32'h00E1_0000;
            32:      m = 32'hA300_0000;
            default: m = 32'h0000_B400;
        endcase
        return m;
    endfunction

    function automatic logic [MAX_COLORS-1:0] onehot(input logic [2:0] idx);
        logic [MAX_COLORS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/seq_lfsr.sv
// Fibonacci LFSR with seed load (zero seed forced to 1) and step enable.
// next_value is combinational; state updates one clock after load/step, never stalls.
module seq_lfsr
    import seq_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] seed,
    output logic [W-1:0] next_value
);

    localparam logic [31:0]  TAPS32 = lfsr_taps(W);
    localparam logic [W-1:0] TAPS   = TAPS32[W-1:0];

    logic [W-1:0] lfsr_q;

    assign next_value = {lfsr_q[W-2:0], ^(lfsr_q & TAPS)};

    // An all-zero state would lock the register, so a zero seed becomes 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= W'(1);
        end else if (load) begin
            lfsr_q <= (seed == '0) ? W'(1) : seed;
        end else if (step) begin
            lfsr_q <= next_value;
        end
    end

endmodule

// File: rtl/seq_player.sv
// Plays a fixed or LFSR-generated colour sequence on one-hot LEDs; led/rd_data registered (1 cycle).
// Start pulses are dropped while busy; the read port runs every cycle regardless of state.
module seq_player
    import seq_pkg::*;
#(
    parameter int N_COLORS = 4,
    parameter int DEPTH    = 16,
    parameter int N_BANKS  = 2,
    parameter int ON_CYC   = 25000000,
    parameter int OFF_CYC  = 12500000,
    parameter int LFSR_W   = 16,
    localparam int AW      = $clog2(DEPTH),
    localparam int BW      = $clog2(N_BANKS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [BW-1:0]       bank_sel,
    input  logic [LFSR_W-1:0]   seed,
    input  logic                gen_start,
    input  logic                play_start,
    input  logic [AW:0]         play_len,
    output logic                busy,
    output logic [N_COLORS-1:0] led,
    output logic                play_done,
    input  logic [AW-1:0]       rd_addr,
    output logic [N_COLORS-1:0] rd_data
);

    localparam int             TMAX      = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
    localparam int             TW        = $clog2(TMAX) + 1;
    localparam logic [TW-1:0]  T_ON      = TW'(ON_CYC - 1);
    localparam logic [TW-1:0]  T_OFF     = TW'(OFF_CYC - 1);
    localparam logic [AW:0]    LEN_MAX   = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0]  STEP_LAST = AW'(DEPTH - 1);

    state_t                state_q, state_d;
    logic [BW-1:0]         bank_q, bank_d;
    logic [AW:0]           len_q, len_d;
    logic [AW-1:0]         step_q, step_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [N_COLORS-1:0]   led_q, led_d;
    logic [N_COLORS-1:0]   rd_q, rd_d;
    logic                  done_q;
    logic                  lfsr_load;
    logic                  gen_we;
    logic [LFSR_W-1:0]     lfsr_nxt;
    logic [N_COLORS-1:0]   gen_oh;
    logic [N_COLORS-1:0]   buf_q [DEPTH];

    seq_lfsr #(
        .W (LFSR_W)
    ) u_lfsr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (lfsr_load),
        .step       (gen_we),
        .seed       (seed),
        .next_value (lfsr_nxt)
    );

    // Bank indices at or above N_BANKS select the LFSR buffer; fixed tables wrap every 16 entries.
    function automatic logic [N_COLORS-1:0] lookup(input logic [BW-1:0] bank,
                                                   input logic [AW-1:0] addr);
        logic [3:0]          t;
        logic [1:0]          c;
        logic [N_COLORS-1:0] r;
        t = 4'(addr);
        if (int'(bank) >= N_BANKS) begin
            r = buf_q[addr];
        end else begin
            c = bank[0] ? BANK1_TBL[{t, 1'b0} +: 2] : BANK0_TBL[{t, 1'b0} +: 2];
            r = N_COLORS'(onehot(3'(32'(c) % N_COLORS)));
        end
        return r;
    endfunction

    assign gen_oh = N_COLORS'(onehot(3'(32'(lfsr_nxt) % N_COLORS)));

    always_comb begin
        state_d   = state_q;
        bank_d    = bank_q;
        len_d     = len_q;
        step_d    = step_q;
        timer_d   = timer_q;
        lfsr_load = 1'b0;
        gen_we    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (gen_start) begin
                    lfsr_load = 1'b1;
                    step_d    = '0;
                    state_d   = ST_GEN;
                end else if (play_start) begin
                    bank_d = bank_sel;
                    len_d  = (int'(play_len) > DEPTH) ? LEN_MAX : play_len;
                    step_d = '0;
                    if (len_d == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ON;
                        timer_d = T_ON;
                    end
                end
            end
            ST_GEN: begin
                gen_we = 1'b1;
                if (step_q == STEP_LAST) begin
                    step_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            ST_ON: begin
                if (timer_q == '0) begin
                    if ({1'b0, step_q} == len_q - 1'b1) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_OFF;
                        timer_d = T_OFF;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_OFF: begin
                if (timer_q == '0) begin
                    step_d  = step_q + 1'b1;
                    state_d = ST_ON;
                    timer_d = T_ON;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered from the next state so the colour is valid on the first ON cycle.
    always_comb begin
        led_d = '0;
        if (state_d == ST_ON) begin
            led_d = lookup(bank_d, step_d);
        end
        rd_d = lookup(bank_q, rd_addr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            bank_q  <= '0;
            len_q   <= '0;
            step_q  <= '0;
            timer_q <= '0;
            led_q   <= '0;
            rd_q    <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= N_COLORS'(onehot(3'd0));
            end
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            len_q   <= len_d;
            step_q  <= step_d;
            timer_q <= timer_d;
            led_q   <= led_d;
            rd_q    <= rd_d;
            done_q  <= (state_d == ST_DONE);
            if (gen_we) begin
                buf_q[step_q] <= gen_oh;
            end
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign led       = led_q;
    assign play_done = done_q;
    assign rd_data   = rd_q;

endmodule

// File: tb/tb_seq_player.sv
// Scoreboard bench for seq_player with short ON/OFF timing and an independent table/LFSR model.
module tb_seq_player;

    localparam int NC  = 4;
    localparam int DP  = 16;
    localparam int ONC = 3;
    localparam int OFC = 2;

    typedef struct {
        logic [3:0] led;
        logic       done;
        logic       busy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  bank_sel = '0;
    logic [15:0] seed = '0;
    logic        gen_start = 1'b0;
    logic        play_start = 1'b0;
    logic [4:0]  play_len = '0;
    logic        busy;
    logic [3:0]  led;
    logic        play_done;
    logic [3:0]  rd_addr = '0;
    logic [3:0]  rd_data;

    int   n_chk  = 0;
    int   n_pass = 0;
    exp_t exp_q[$];
    logic [3:0] rd_exp_q[$];

    int         b0 [16] = '{0, 2, 0, 3, 1, 0, 3, 2, 0, 1, 0, 3, 2, 1, 3, 0};
    logic [3:0] mbuf [16];

    seq_player #(
        .N_COLORS (NC),
        .DEPTH    (DP),
        .N_BANKS  (2),
        .ON_CYC   (ONC),
        .OFF_CYC  (OFC),
        .LFSR_W   (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bank_sel   (bank_sel),
        .seed       (seed),
        .gen_start  (gen_start),
        .play_start (play_start),
        .play_len   (play_len),
        .busy       (busy),
        .led        (led),
        .play_done  (play_done),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [3:0] model_entry(input int bank, input int s);
        logic [3:0] r;
        if (bank >= 2) r = mbuf[s];
        else if (bank == 1) r = 4'b0001 << b0[15 - s];
        else r = 4'b0001 << b0[s];
        return r;
    endfunction

    task automatic push_play(input int bank, input int len);
        int l;
        l = (len > DP) ? DP : len;
        for (int s = 0; s < l; s++) begin
            for (int c = 0; c < ONC; c++) exp_q.push_back('{model_entry(bank, s), 1'b0, 1'b1});
            if (s != l - 1)
                for (int c = 0; c < OFC; c++) exp_q.push_back('{4'b0000, 1'b0, 1'b1});
        end
        exp_q.push_back('{4'b0000, 1'b1, 1'b1});
        exp_q.push_back('{4'b0000, 1'b0, 1'b0});
    endtask

    // Compares up to n queued cycles; optionally pulses play_start at cycle poke_at.
    task automatic drain(input int n, input int poke_at);
        exp_t e;
        int   k;
        k = 0;
        while (exp_q.size() > 0 && k < n) begin
            k++;
            e = exp_q.pop_front();
            chk("led", 32'(led), 32'(e.led));
            chk("play_done", 32'(play_done), 32'(e.done));
            chk("busy", 32'(busy), 32'(e.busy));
            play_start = (k == poke_at);
            if (k == poke_at) begin
                bank_sel = 2'd1;
                play_len = 5'd1;
            end
            if (exp_q.size() > 0 && k < n) @(negedge clk);
        end
        play_start = 1'b0;
    endtask

    task automatic play(input int bank, input int len, input int poke_at);
        bank_sel   = 2'(bank);
        play_len   = 5'(len);
        play_start = 1'b1;
        push_play(bank, len);
        @(negedge clk);
        play_start = 1'b0;
        drain(10000, poke_at);
    endtask

    task automatic sweep(input int bank, input int first, input int last);
        for (int a = first; a <= last; a++) begin
            rd_addr = 4'(a);
            rd_exp_q.push_back(model_entry(bank, a));
            @(negedge clk);
            chk($sformatf("rd_data[%0d]", a), 32'(rd_data), 32'(rd_exp_q.pop_front()));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 16; i++) mbuf[i] = 4'b0001;
        repeat (3) @(negedge clk);
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(play_done), 32'd0);
        chk("rst_rd", 32'(rd_data), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        play(0, 3, 4);
        play(0, 0, 0);
        play(0, 20, 0);

        // Zero seed behaves as seed 1; simultaneous play_start must be dropped.
        begin
            logic [15:0] l;
            l = 16'd1;
            for (int i = 0; i < 16; i++) begin
                l = lfsr_next(l);
                mbuf[i] = 4'b0001 << (l % 4);
            end
        end
        seed       = 16'd0;
        gen_start  = 1'b1;
        play_start = 1'b1;
        bank_sel   = 2'd0;
        play_len   = 5'd3;
        for (int i = 0; i < 16; i++) exp_q.push_back('{4'b0000, 1'b0, 1'b1});
        for (int i = 0; i < 4; i++) exp_q.push_back('{4'b0000, 1'b0, 1'b0});
        @(negedge clk);
        gen_start  = 1'b0;
        play_start = 1'b0;
        drain(10000, 0);

        play(2, 0, 0);
        sweep(2, 0, 15);
        play(2, 2, 0);

        play(1, 0, 0);
        sweep(1, 0, 1);

        // Reset in the middle of step 5's ON phase.
        bank_sel   = 2'd0;
        play_len   = 5'd16;
        play_start = 1'b1;
        push_play(0, 16);
        @(negedge clk);
        play_start = 1'b0;
        drain(27, 0);
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        chk("arst_led", 32'(led), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(play_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) mbuf[i] = 4'b0001;
        @(negedge clk);
        play(2, 0, 0);
        sweep(2, 0, 15);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
